// File: rtl/conv_encoder_sys.sv
// Rate-1/2 feed-forward convolutional encoder, K = 3..6 chosen per frame.
// Every frame is followed by K-1 zero tail bits so the trellis ends in state 0.
module conv_encoder_sys #(
  parameter int FRAME_LEN = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] choose_constraint_length,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic [1:0] encoded_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

  localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t     state, state_nxt;
  logic [4:0] sr;
  logic [7:0] bit_cnt;
  logic [2:0] tail_cnt;
  logic [2:0] k_r, k_sel, k_use;
  logic       ready_q;
  logic       slot_free, step, enc_in, last_step;
  logic [5:0] vec, mask_g0, mask_g1;
  logic [1:0] enc;

  assign slot_free = !out_valid || out_ready;
  assign k_sel     = (choose_constraint_length >= 3'd3 && choose_constraint_length <= 3'd6)
                     ? choose_constraint_length : 3'd3;
  // The first bit of a frame must use the K being latched, not the old one.
  assign k_use     = (state == IDLE) ? k_sel : k_r;
  assign busy      = (state != IDLE);

  // Generators are left-aligned so the MSB tap always lands on the input bit.
  assign vec = {enc_in, sr[0], sr[1], sr[2], sr[3], sr[4]};

  always_comb begin
    mask_g0 = 6'b111000;
    mask_g1 = 6'b101000;
    case (k_use)
      3'd4: begin mask_g0 = 6'b111100; mask_g1 = 6'b110100; end
      3'd5: begin mask_g0 = 6'b100110; mask_g1 = 6'b111010; end
      3'd6: begin mask_g0 = 6'b101011; mask_g1 = 6'b111101; end
      default: begin mask_g0 = 6'b111000; mask_g1 = 6'b101000; end
    endcase
  end

  assign enc = {^(vec & mask_g0), ^(vec & mask_g1)};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    step      = 1'b0;
    enc_in    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ready_q && slot_free;
        enc_in   = in_bit;
        if (in_valid && ready_q && slot_free) begin
          step      = 1'b1;
          state_nxt = (FRAME_LEN_W == 8'd1) ? TAIL : DATA;
        end
      end
      DATA: begin
        in_ready = ready_q && slot_free;
        enc_in   = in_bit;
        if (in_valid && ready_q && slot_free) begin
          step = 1'b1;
          if (bit_cnt + 8'd1 == FRAME_LEN_W) state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (slot_free) begin
          step = 1'b1;
          if (tail_cnt + 3'd1 == k_r - 3'd1) begin
            last_step = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      tail_cnt     <= '0;
      k_r          <= 3'd3;
      encoded_bits <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      if (step) begin
        encoded_bits <= enc;
        out_valid    <= 1'b1;
        out_last     <= last_step;
        // Clearing the whole register also drops stale bits beyond a short K.
        sr           <= last_step ? 5'd0 : {sr[3:0], enc_in};
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (state == IDLE && step) begin
        k_r     <= k_sel;
        bit_cnt <= 8'd1;
      end else if (state == DATA && step) begin
        bit_cnt <= bit_cnt + 8'd1;
      end
      if (state == TAIL && step) tail_cnt <= last_step ? 3'd0 : tail_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Directed bench for conv_encoder_sys: FRAME_LEN=4 and FRAME_LEN=13 instances
// share stimulus; 'sel' chooses which one is fed and observed.
module tb_conv_encoder_sys;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_bit, out_ready, sel;
  logic [2:0] cfg_k;

  logic       in_ready4, out_valid4, out_last4, busy4;
  logic [1:0] enc4;
  logic       in_ready13, out_valid13, out_last13, busy13;
  logic [1:0] enc13;

  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] enc;

  assign in_ready  = sel ? in_ready13  : in_ready4;
  assign out_valid = sel ? out_valid13 : out_valid4;
  assign out_last  = sel ? out_last13  : out_last4;
  assign busy      = sel ? busy13      : busy4;
  assign enc       = sel ? enc13       : enc4;

  conv_encoder_sys #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .choose_constraint_length(cfg_k),
    .in_valid(in_valid && !sel), .in_ready(in_ready4), .in_bit(in_bit),
    .encoded_bits(enc4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_last(out_last4), .busy(busy4)
  );

  conv_encoder_sys #(.FRAME_LEN(13)) dut13 (
    .clk(clk), .rst(rst), .choose_constraint_length(cfg_k),
    .in_valid(in_valid && sel), .in_ready(in_ready13), .in_bit(in_bit),
    .encoded_bits(enc13), .out_valid(out_valid13), .out_ready(out_ready),
    .out_last(out_last13), .busy(busy13)
  );

  int tests = 0;
  int fails = 0;

  logic       bits_q[$];
  logic [2:0] k_q[$];
  logic [1:0] sym_q[$];
  logic       last_q[$];
  logic [3:0] rdy_pat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bits are taken MSB first from b.
  task automatic push_bits(input logic [2:0] k, input int n, input logic [31:0] b);
    for (int i = 0; i < n; i++) begin
      bits_q.push_back(b[n-1-i]);
      k_q.push_back(k);
    end
  endtask

  // Symbols are 2-bit pairs, first symbol in the most significant pair; last one carries out_last.
  task automatic expect_syms(input int n, input logic [63:0] s);
    for (int i = 0; i < n; i++) begin
      sym_q.push_back(s[2*(n-1-i) +: 2]);
      last_q.push_back(i == n - 1);
    end
  endtask

  // mode 0: out_ready always high; mode 1: out_ready follows rdy_pat.
  task automatic run_stream(input int mode, input string name);
    int   bi = 0;
    int   si = 0;
    int   cyc = 0;
    int   first = -1;
    int   lastc = 0;
    logic stall = 1'b0;
    logic [1:0] held = 2'b00;
    logic held_last = 1'b0;
    while (si < sym_q.size() && cyc < 400) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
      if (bi < bits_q.size()) begin
        in_valid = 1'b1;
        in_bit   = bits_q[bi];
        cfg_k    = k_q[bi];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        check($sformatf("%s hold_valid", name), 32'(out_valid), 32'd1);
        check($sformatf("%s hold_enc", name), 32'(enc), 32'(held));
        check($sformatf("%s hold_last", name), 32'(out_last), 32'(held_last));
        stall = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("%s sym%0d", name, si), 32'(enc), 32'(sym_q[si]));
          check($sformatf("%s last%0d", name, si), 32'(out_last), 32'(last_q[si]));
          check($sformatf("%s busy%0d", name, si), 32'(busy), 32'(!last_q[si]));
          if (first < 0) first = cyc;
          lastc = cyc;
          si++;
        end else begin
          stall     = 1'b1;
          held      = enc;
          held_last = out_last;
          check($sformatf("%s in_ready_full", name), 32'(in_ready), 32'd0);
        end
      end
      if (in_valid && in_ready) bi++;
      cyc++;
    end
    check($sformatf("%s symbol_count", name), 32'(si), 32'(sym_q.size()));
    check($sformatf("%s bits_taken", name), 32'(bi), 32'(bits_q.size()));
    if (mode == 0 && first >= 0)
      check($sformatf("%s gapless", name), 32'(lastc - first), 32'(sym_q.size() - 1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check($sformatf("%s idle_busy", name), 32'(busy), 32'd0);
    bits_q.delete();
    k_q.delete();
    sym_q.delete();
    last_q.delete();
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1; cfg_k = 3'd3;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("ready after reset", 32'(in_ready), 32'd1);

    push_bits(3'd3, 4, 32'b1011);
    expect_syms(6, 64'b11_10_00_01_01_11);
    run_stream(0, "k3");

    push_bits(3'd3, 4, 32'b1011);
    expect_syms(6, 64'b11_10_00_01_01_11);
    run_stream(1, "k3_stall");

    push_bits(3'd6, 4, 32'b1000);
    expect_syms(9, 64'b11_01_11_01_10_11_00_00_00);
    run_stream(0, "k6");

    push_bits(3'd7, 4, 32'b1000);
    expect_syms(6, 64'b11_10_11_00_00_00);
    run_stream(0, "k7_as_k3");

    push_bits(3'd3, 4, 32'b1011);
    push_bits(3'd5, 4, 32'b1100);
    expect_syms(6, 64'b11_10_00_01_01_11);
    expect_syms(8, 64'b11_10_00_11_01_11_00_00);
    run_stream(0, "b2b");

    // Two bits into a frame, then reset; the next frame must start from sr = 0.
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1; cfg_k = 3'd3; out_ready = 1'b1;
    @(negedge clk);
    in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    push_bits(3'd3, 4, 32'b1011);
    expect_syms(6, 64'b11_10_00_01_01_11);
    run_stream(0, "after_reset");

    sel = 1'b1;
    push_bits(3'd3, 13, 32'd0);
    push_bits(3'd3, 13, 32'b1_0000_0000_0000);
    expect_syms(15, 64'd0);
    expect_syms(15, 64'(30'b11_10_11_00_00_00_00_00_00_00_00_00_00_00_00));
    run_stream(0, "len13");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
